// File: rtl/sgd_rd_x_from_memory.sv
// Loads the x vector from host memory with one DMA read and scatters the
// returned 512-bit beats into 2048-bit engine words, one x bank per engine.
module sgd_rd_x_from_memory #(
  parameter int ENGINE_NUM        = 8,
  parameter int NUM_BITS_PER_BANK = 64,
  parameter int X_ADDR_BITS       = 9
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [63:0]                     addr_model,
  input  logic [31:0]                     dimension,
  output logic                            busy,
  output logic                            done,
  output logic                            error,
  output logic                            x_data_rd_start,
  output logic [63:0]                     x_data_rd_addr,
  output logic [31:0]                     x_data_rd_length,
  input  logic [511:0]                    x_data_in,
  input  logic                            x_data_in_valid,
  output logic                            x_data_in_ready,
  output logic [ENGINE_NUM-1:0]           x_mem_wr_en,
  output logic [X_ADDR_BITS-1:0]          x_mem_wr_addr,
  output logic [NUM_BITS_PER_BANK*32-1:0] x_mem_wr_data,
  output logic [31:0]                     state_counters_rd_x_from_memory
);

  localparam int WORD_W = NUM_BITS_PER_BANK * 32;
  localparam int ENG_W  = (ENGINE_NUM > 1) ? $clog2(ENGINE_NUM) : 1;
  localparam logic [31:0]      ROW_FEATURES = 32'(ENGINE_NUM * NUM_BITS_PER_BANK);
  localparam logic [31:0]      ROW_BYTES    = 32'(ENGINE_NUM * 4 * 64);
  localparam logic [ENG_W-1:0] ENG_LAST     = ENG_W'(ENGINE_NUM - 1);

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_CMD  = 4'b0010,
    ST_DATA = 4'b0100,
    ST_END  = 4'b1000
  } state_t;

  state_t                  state_r, next_state_s;
  logic [1:0]              inner_r;
  logic [ENG_W-1:0]        engine_r;
  logic [31:0]             row_r;
  logic [31:0]             rows_r;
  logic [WORD_W-1:0]       word_r;
  logic                    error_r, busy_r, done_r, rd_start_r, ready_r;
  logic [63:0]             rd_addr_r;
  logic [31:0]             rd_len_r;
  logic [ENGINE_NUM-1:0]   wr_en_r;
  logic [X_ADDR_BITS-1:0]  wr_addr_r;
  logic [31:0]             rows_s;
  logic [31:0]             len_s;
  logic [ENGINE_NUM-1:0]   onehot_s;
  logic [3:0]              eng_dbg_s;
  logic                    accept_s, fire_s, last_beat_s;

  assign accept_s    = (state_r == ST_IDLE) && start;
  assign fire_s      = ready_r && x_data_in_valid;
  assign last_beat_s = fire_s && (inner_r == 2'd3) && (engine_r == ENG_LAST) &&
                       (row_r == (rows_r - 32'd1));

  // Row count rounded up without a pre-add, so it cannot overflow 32 bits.
  always_comb begin
    rows_s = dimension / ROW_FEATURES;
    if ((dimension % ROW_FEATURES) != 32'd0) begin
      rows_s = rows_s + 32'd1;
    end else begin
      rows_s = rows_s;
    end
    len_s = rows_s * ROW_BYTES;
  end

  // One-hot engine select for the bank being written.
  always_comb begin
    onehot_s = {ENGINE_NUM{1'b0}};
    for (int e = 0; e < ENGINE_NUM; e++) begin
      onehot_s[e] = (engine_r == ENG_W'(e));
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (dimension == 32'd0) begin
            next_state_s = ST_END;
          end else begin
            next_state_s = ST_CMD;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_CMD:  next_state_s = ST_DATA;
      ST_DATA: begin
        if (last_beat_s) begin
          next_state_s = ST_END;
        end else begin
          next_state_s = ST_DATA;
        end
      end
      ST_END:  next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State register, registered handshake/status outputs and command capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
      rd_start_r <= 1'b0;
      ready_r    <= 1'b0;
      rd_addr_r  <= 64'd0;
      rd_len_r   <= 32'd0;
      rows_r     <= 32'd0;
    end else begin
      state_r    <= next_state_s;
      busy_r     <= (next_state_s != ST_IDLE);
      rd_start_r <= (next_state_s == ST_CMD);
      ready_r    <= (next_state_s == ST_DATA);
      done_r     <= (state_r == ST_END);
      if (accept_s) begin
        error_r   <= (dimension == 32'd0);
        rd_addr_r <= addr_model;
        rd_len_r  <= len_s;
        rows_r    <= rows_s;
      end
    end
  end

  // Beat packing and inner/engine/row counters; the engine word is written
  // the cycle after its 4th beat, before the next beat can overwrite slice 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inner_r   <= 2'd0;
      engine_r  <= {ENG_W{1'b0}};
      row_r     <= 32'd0;
      word_r    <= {WORD_W{1'b0}};
      wr_en_r   <= {ENGINE_NUM{1'b0}};
      wr_addr_r <= {X_ADDR_BITS{1'b0}};
    end else begin
      wr_en_r <= {ENGINE_NUM{1'b0}};
      if (fire_s) begin
        word_r[{inner_r, 9'd0} +: 512] <= x_data_in;
        if (inner_r == 2'd3) begin
          wr_en_r   <= onehot_s;
          wr_addr_r <= row_r[X_ADDR_BITS-1:0];
          inner_r   <= 2'd0;
          if (last_beat_s) begin
            engine_r <= {ENG_W{1'b0}};
            row_r    <= 32'd0;
          end else if (engine_r == ENG_LAST) begin
            engine_r <= {ENG_W{1'b0}};
            row_r    <= row_r + 32'd1;
          end else begin
            engine_r <= engine_r + {{(ENG_W-1){1'b0}}, 1'b1};
          end
        end else begin
          inner_r <= inner_r + 2'd1;
        end
      end
    end
  end

  assign eng_dbg_s        = 4'(engine_r);
  assign busy             = busy_r;
  assign done             = done_r;
  assign error            = error_r;
  assign x_data_rd_start  = rd_start_r;
  assign x_data_rd_addr   = rd_addr_r;
  assign x_data_rd_length = rd_len_r;
  assign x_data_in_ready  = ready_r;
  assign x_mem_wr_en      = wr_en_r;
  assign x_mem_wr_addr    = wr_addr_r;
  assign x_mem_wr_data    = word_r;
  assign state_counters_rd_x_from_memory =
    {5'd0, error_r, row_r[15:0], eng_dbg_s, inner_r, state_r};

endmodule

// File: tb/tb_sgd_rd_x_from_memory.sv
// Directed/randomized bench for sgd_rd_x_from_memory; expected engine writes
// are derived from the beat stream by plain row/engine/beat arithmetic.
module tb_sgd_rd_x_from_memory;
  localparam int E  = 8;
  localparam int WW = 2048;

  logic           clk = 1'b0;
  logic           rst_n, start;
  logic [63:0]    addr_model;
  logic [31:0]    dimension;
  logic           busy, done, error;
  logic           x_data_rd_start;
  logic [63:0]    x_data_rd_addr;
  logic [31:0]    x_data_rd_length;
  logic [511:0]   x_data_in;
  logic           x_data_in_valid, x_data_in_ready;
  logic [E-1:0]   x_mem_wr_en;
  logic [8:0]     x_mem_wr_addr;
  logic [WW-1:0]  x_mem_wr_data;
  logic [31:0]    state_counters;

  always #5 clk = ~clk;

  sgd_rd_x_from_memory dut (
    .clk(clk), .rst_n(rst_n), .start(start), .addr_model(addr_model),
    .dimension(dimension), .busy(busy), .done(done), .error(error),
    .x_data_rd_start(x_data_rd_start), .x_data_rd_addr(x_data_rd_addr),
    .x_data_rd_length(x_data_rd_length), .x_data_in(x_data_in),
    .x_data_in_valid(x_data_in_valid), .x_data_in_ready(x_data_in_ready),
    .x_mem_wr_en(x_mem_wr_en), .x_mem_wr_addr(x_mem_wr_addr),
    .x_mem_wr_data(x_mem_wr_data),
    .state_counters_rd_x_from_memory(state_counters)
  );

  int tests = 0;
  int fails = 0;
  logic [511:0] beat_mem [0:63];

  logic [E-1:0]  mon_en_q   [$];
  logic [8:0]    mon_addr_q [$];
  logic [WW-1:0] mon_data_q [$];
  longint        mon_wr_t   [$];
  int            rd_cnt, done_cnt;
  logic [63:0]   rd_addr_seen;
  logic [31:0]   rd_len_seen;
  longint        done_t;

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (x_mem_wr_en != {E{1'b0}}) begin
      mon_en_q.push_back(x_mem_wr_en);
      mon_addr_q.push_back(x_mem_wr_addr);
      mon_data_q.push_back(x_mem_wr_data);
      mon_wr_t.push_back($time);
    end
    if (x_data_rd_start) begin
      rd_cnt++;
      rd_addr_seen = x_data_rd_addr;
      rd_len_seen  = x_data_rd_length;
    end
    if (done) begin
      done_cnt++;
      done_t = $time;
    end
  end

  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h (low 128 bits)", tag, obs[127:0], exp[127:0]);
    end
  endtask

  task automatic clear_mon();
    mon_en_q.delete(); mon_addr_q.delete(); mon_data_q.delete(); mon_wr_t.delete();
    rd_cnt = 0; done_cnt = 0; done_t = 0;
  endtask

  task automatic fill_beats();
    for (int b = 0; b < 64; b++)
      for (int w = 0; w < 16; w++)
        beat_mem[b][32*w +: 32] = $urandom;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_error"}, error, 1'b0);
    chk({tag, "_rd_start"}, x_data_rd_start, 1'b0);
    chk({tag, "_rd_addr"}, x_data_rd_addr, 64'd0);
    chk({tag, "_rd_len"}, x_data_rd_length, 32'd0);
    chk({tag, "_ready"}, x_data_in_ready, 1'b0);
    chk({tag, "_wr_en"}, x_mem_wr_en, 8'd0);
    chk({tag, "_wr_addr"}, x_mem_wr_addr, 9'd0);
    chk({tag, "_wr_data"}, x_mem_wr_data, {WW{1'b0}});
    chk({tag, "_state_counters"}, state_counters, 32'h0000_0001);
  endtask

  task automatic run_xfer(input logic [31:0] dim, input logic [63:0] addr, input int gap_pct,
                          input bit regen, input int start_at, input int abort_at);
    int rows, nbeats, i, cyc;
    bit vld, rdy, start_fired;
    longint t_start;
    logic [E-1:0]  exp_en;
    logic [WW-1:0] exp_word;
    rows   = int'(dim / 32'd512) + (((dim % 32'd512) != 32'd0) ? 1 : 0);
    nbeats = rows * 32;
    if (regen) fill_beats();
    clear_mon();
    @(negedge clk);
    start = 1'b1; dimension = dim; addr_model = addr; t_start = $time;
    @(negedge clk);
    start = 1'b0; dimension = $urandom; addr_model = {$urandom, $urandom};
    if (start_at >= 0) dimension = 32'd0;
    i = 0; cyc = 0; start_fired = 1'b0;
    while (i < nbeats && cyc < 4000) begin
      vld = ($urandom_range(99) >= gap_pct);
      x_data_in = beat_mem[i];
      x_data_in_valid = vld;
      if (start_at >= 0 && i == start_at && !start_fired) begin
        start = 1'b1;
        start_fired = 1'b1;
      end
      rdy = x_data_in_ready;
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (vld && rdy) i++;
      if (abort_at >= 0 && i == abort_at) begin
        rst_n = 1'b0;
        x_data_in_valid = 1'b0;
        return;
      end
    end
    x_data_in_valid = 1'b0;
    chk("beats_consumed", i, nbeats);
    for (int w = 0; w < 20 && done_cnt == 0; w++) @(negedge clk);
    repeat (3) @(negedge clk);

    chk("rd_start_count", rd_cnt, (dim != 32'd0) ? 1 : 0);
    if (dim != 32'd0) begin
      chk("rd_addr", rd_addr_seen, addr);
      chk("rd_length", rd_len_seen, 32'(rows * E * 4 * 64));
    end
    chk("wr_count", mon_en_q.size(), rows * E);
    for (int k = 0; k < mon_en_q.size() && k < rows * E; k++) begin
      exp_en = {E{1'b0}};
      exp_en[k % E] = 1'b1;
      exp_word = {beat_mem[4*k+3], beat_mem[4*k+2], beat_mem[4*k+1], beat_mem[4*k]};
      chk("wr_en", mon_en_q[k], exp_en);
      chk("wr_addr", mon_addr_q[k], 9'(k / E));
      chk("wr_data", mon_data_q[k], exp_word);
    end
    chk("done_count", done_cnt, 1);
    if (mon_wr_t.size() > 0)
      chk("done_after_last_wr", done_t - mon_wr_t[$], 10);
    else
      chk("dim0_done_latency", (done_cnt > 0) && ((done_t - t_start) <= 20), 1'b1);
    chk("error_flag", error, dim == 32'd0);
    chk("busy_after", busy, 1'b0);
    chk("state_counters_after", state_counters,
        (dim == 32'd0) ? 32'h0400_0001 : 32'h0000_0001);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; addr_model = 64'd0; dimension = 32'd0;
    x_data_in = 512'd0; x_data_in_valid = 1'b0;
    clear_mon();
    repeat (3) @(negedge clk);
    reset_checks("por");
    rst_n = 1'b1;
    @(negedge clk);
    fill_beats();

    run_xfer(32'd512, 64'h1000, 0, 1'b0, -1, -1);
    run_xfer(32'd512, 64'h1000, 50, 1'b0, -1, -1);
    run_xfer(32'd1000, {$urandom, $urandom}, 0, 1'b1, -1, -1);
    run_xfer(32'd0, 64'h2000, 0, 1'b0, -1, -1);
    run_xfer(32'd512, 64'h3000, 20, 1'b1, 5, -1);

    // Reset asserted after 10 accepted beats must abort cleanly.
    run_xfer(32'd512, 64'h4000, 0, 1'b1, -1, 10);
    @(negedge clk);
    reset_checks("mid_rst");
    clear_mon();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_abort_wr", mon_en_q.size(), 0);
    chk("post_abort_done", done_cnt, 0);
    chk("post_abort_rd", rd_cnt, 0);
    run_xfer(32'd512, 64'h5000, 0, 1'b1, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
